// File: rtl/fpu_scoreboard.sv
// Register scoreboard for multi-cycle FPU ops: tracks pending destinations,
// flags RAW/WAW hazards in E and counts ops in flight. Optional macro:
// FPU_SCOREBOARD_BYPASS_EN lets a same-cycle writeback release its register.
module fpu_scoreboard #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       issue_valid,
  input  logic [5:0] issue_rd,
  input  logic       fpu_op_e,
  input  logic [5:0] Rs1E,
  input  logic [5:0] Rs2E,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic       StallE,
  input  logic       wb_valid,
  input  logic [5:0] wb_rd,
  output logic       operand_invalid1,
  output logic       operand_invalid2,
  output logic       waw_hit,
  output logic       full,
  output logic       use_prev_data1,
  output logic       use_prev_data2,
  output logic [2:0] inflight
);

  localparam logic [2:0] DepthC = 3'(DEPTH);

  logic [63:0] pending_q, pending_d;
  logic [2:0]  inflight_q, inflight_d;
  logic        use_prev1_q, use_prev2_q;
  logic [63:0] pend_view;
  logic        wb_hit, dec, issue_ok;

`ifdef FPU_SCOREBOARD_BYPASS_EN
  // A register being written back this cycle is already readable.
  assign pend_view = wb_valid ? (pending_q & ~(64'd1 << wb_rd)) : pending_q;
`else
  assign pend_view = pending_q;
`endif

  assign operand_invalid1 = rs1_used & (Rs1E != 6'd0) & pend_view[Rs1E];
  assign operand_invalid2 = rs2_used & (Rs2E != 6'd0) & pend_view[Rs2E];
  assign waw_hit          = fpu_op_e & (issue_rd != 6'd0) & pend_view[issue_rd];
  assign full             = (inflight_q == DepthC);
  assign inflight         = inflight_q;
  assign use_prev_data1   = use_prev1_q;
  assign use_prev_data2   = use_prev2_q;

  // x0 writebacks retire an untracked op; writebacks to non-pending
  // registers (e.g. ops lost across a reset) do not count.
  assign wb_hit   = wb_valid & ((wb_rd == 6'd0) | pending_q[wb_rd]);
  assign dec      = wb_hit & (inflight_q != 3'd0);
  assign issue_ok = issue_valid & (~full | dec);

  always_comb begin
    pending_d = pending_q;
    if (wb_valid) pending_d[wb_rd] = 1'b0;
    // Issue is applied after writeback so the new op owns the register.
    if (issue_ok && issue_rd != 6'd0) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue_ok, dec})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q   <= '0;
      inflight_q  <= '0;
      use_prev1_q <= 1'b0;
      use_prev2_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      inflight_q  <= inflight_d;
      use_prev1_q <= ~operand_invalid1 & StallE;
      use_prev2_q <= ~operand_invalid2 & StallE;
    end
  end

  // Upstream must not issue into a full scoreboard unless a slot retires.
  assert property (@(posedge clk) disable iff (!rstn)
                   !(issue_valid && full && !dec))
    else $error("fpu_scoreboard: issue while full dropped");

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Directed bench for fpu_scoreboard (DEPTH=4); expectations follow the
// build's FPU_SCOREBOARD_BYPASS_EN setting.
module tb_fpu_scoreboard;

  logic       clk = 1'b0;
  logic       rstn;
  logic       issue_valid, fpu_op_e, rs1_used, rs2_used, StallE, wb_valid;
  logic [5:0] issue_rd, Rs1E, Rs2E, wb_rd;
  logic       operand_invalid1, operand_invalid2, waw_hit, full;
  logic       use_prev_data1, use_prev_data2;
  logic [2:0] inflight;

  int tests  = 0;
  int failed = 0;

`ifdef FPU_SCOREBOARD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  fpu_scoreboard #(.DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .fpu_op_e(fpu_op_e),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .StallE(StallE), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .operand_invalid1(operand_invalid1), .operand_invalid2(operand_invalid2),
    .waw_hit(waw_hit), .full(full),
    .use_prev_data1(use_prev_data1), .use_prev_data2(use_prev_data2),
    .inflight(inflight)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0; fpu_op_e = 0;
    Rs1E = 0; Rs2E = 0; rs1_used = 0; rs2_used = 0;
    StallE = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic issue(input logic [5:0] rd);
    idle_inputs();
    issue_valid = 1; issue_rd = rd;
    tick();
    issue_valid = 0;
  endtask

  task automatic wb(input logic [5:0] rd);
    idle_inputs();
    wb_valid = 1; wb_rd = rd;
    tick();
    wb_valid = 0;
  endtask

  initial begin
    // reset
    idle_inputs();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_inflight", inflight, 0);
    check("rst_full", full, 0);
    check("rst_use_prev1", use_prev_data1, 0);
    rstn = 1;
    tick();

    // RAW on rd 40 and its release
    issue(6'd40);
    Rs1E = 40; rs1_used = 1; #1;
    check("raw40_inv1", operand_invalid1, 1);
    check("raw40_inflight", inflight, 1);
    wb_valid = 1; wb_rd = 40; #1;
    check("raw40_wb_cycle_inv1", operand_invalid1, {31'd0, ~BYP});
    tick();
    wb_valid = 0; #1;
    check("raw40_after_wb_inv1", operand_invalid1, 0);
    check("raw40_after_wb_inflight", inflight, 0);

    // rd 0: counted, never tracked
    issue(6'd0);
    check("x0_inflight", inflight, 1);
    Rs1E = 0; rs1_used = 1; fpu_op_e = 1; issue_rd = 0; #1;
    check("x0_inv1", operand_invalid1, 0);
    check("x0_waw", waw_hit, 0);
    wb(6'd0);
    check("x0_wb_inflight", inflight, 0);
    wb(6'd0);
    check("x0_wb_at_zero", inflight, 0);

    // fill to DEPTH
    issue(6'd33); issue(6'd34); issue(6'd35);
    check("fill3_inflight", inflight, 3);
    check("fill3_full", full, 0);
    issue(6'd36);
    check("fill4_inflight", inflight, 4);
    check("fill4_full", full, 1);
    // retire 33 and issue 37 together while full
    idle_inputs();
    wb_valid = 1; wb_rd = 33; issue_valid = 1; issue_rd = 37;
    tick();
    idle_inputs();
    Rs1E = 33; rs1_used = 1; Rs2E = 37; rs2_used = 1; #1;
    check("swap_full", full, 1);
    check("swap_inflight", inflight, 4);
    check("swap_inv1_33", operand_invalid1, 0);
    check("swap_inv2_37", operand_invalid2, 1);
    wb(6'd34); wb(6'd35); wb(6'd36);
    check("drain3_full", full, 0);
    check("drain3_inflight", inflight, 1);
    wb(6'd37);
    check("drain_inflight", inflight, 0);

    // issue and writeback of the same register: new op wins
    issue(6'd45);
    idle_inputs();
    wb_valid = 1; wb_rd = 45; issue_valid = 1; issue_rd = 45;
    tick();
    idle_inputs();
    Rs1E = 45; rs1_used = 1; #1;
    check("same45_inv1", operand_invalid1, 1);
    check("same45_inflight", inflight, 1);
    wb(6'd45);
    check("same45_drain", inflight, 0);

    // WAW on 50 and unused source
    issue(6'd50);
    fpu_op_e = 1; issue_rd = 50; Rs2E = 50; rs2_used = 0; #1;
    check("waw50", waw_hit, 1);
    check("waw50_rs2_unused", operand_invalid2, 0);
    rs2_used = 1; #1;
    check("waw50_rs2_used", operand_invalid2, 1);
    wb_valid = 1; wb_rd = 50; #1;
    check("waw50_wb_cycle", waw_hit, {31'd0, ~BYP});
    tick();
    idle_inputs();
    fpu_op_e = 1; issue_rd = 50; #1;
    check("waw50_cleared", waw_hit, 0);

    // stall operand reuse
    idle_inputs();
    StallE = 1; Rs1E = 10; rs1_used = 1;
    tick();
    check("stall_clean_up1", use_prev_data1, 1);
    check("stall_clean_up2", use_prev_data2, 1);
    issue(6'd10);
    StallE = 1; Rs1E = 10; rs1_used = 1; #1;
    check("stall_raw_inv1", operand_invalid1, 1);
    tick();
    check("stall_raw_up1", use_prev_data1, 0);
    check("stall_raw_up2", use_prev_data2, 1);
    StallE = 0;
    tick();
    check("unstall_up2", use_prev_data2, 0);

    // reset mid-operation with three ops in flight
    issue(6'd11); issue(6'd12);
    check("pre_rst_inflight", inflight, 3);
    StallE = 1; fpu_op_e = 1; issue_rd = 11; Rs1E = 10; rs1_used = 1;
    tick();
    check("pre_rst_up2", use_prev_data2, 1);
    check("pre_rst_waw", waw_hit, 1);
    #2 rstn = 0; #1;
    check("async_rst_inflight", inflight, 0);
    check("async_rst_full", full, 0);
    check("async_rst_inv1", operand_invalid1, 0);
    check("async_rst_waw", waw_hit, 0);
    check("async_rst_up1", use_prev_data1, 0);
    check("async_rst_up2", use_prev_data2, 0);
    idle_inputs();
    tick();
    rstn = 1;
    wb(6'd33);
    check("post_rst_wb33", inflight, 0);
    wb(6'd10);
    check("post_rst_wb10", inflight, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
